// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx
//   Receives PS/2 keyboard frames (scan-code set 2) and translates them into the
//   8-bit HID-style keycode bus used by the tank controllers. The most recently
//   pressed mapped key is held on 'keycode' until that key is released.
//
// Ports
//   Clk         in   system clock (50 MHz)
//   Reset       in   synchronous, active-high reset
//   ps2_clk     in   raw PS/2 clock, asynchronous
//   ps2_data    in   raw PS/2 data, asynchronous
//   keycode     out  translated held key, 8'h00 = no mapped key held
//   key_valid   out  1-cycle pulse on each accepted mapped make code
//   rx_byte     out  last correctly framed raw byte
//   rx_strobe   out  1-cycle pulse when rx_byte updates
//   parity_err  out  1-cycle pulse, byte failed odd parity
//   frame_err   out  1-cycle pulse, stop bit sampled 0
module ps2_keycode_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keycode,
   output logic       key_valid,
   output logic [7:0] rx_byte,
   output logic       rx_strobe,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {B_IDLE, B_DATA, B_PARITY, B_STOP} bit_state_t;
   typedef enum logic [1:0] {P_NORM, P_EXT, P_BRK, P_EXTBRK} pfx_state_t;

   function automatic logic [7:0] map_code(input logic [7:0] code, input logic ext);
      logic [7:0] k;
      case ({ext, code})
         9'h01D:  k = 8'h1A;   // W
         9'h01B:  k = 8'h16;   // S
         9'h01C:  k = 8'h04;   // A
         9'h023:  k = 8'h07;   // D
         9'h029:  k = 8'h2C;   // space
         9'h05A:  k = 8'h28;   // enter
         9'h175:  k = 8'h52;   // up
         9'h172:  k = 8'h51;   // down
         9'h16B:  k = 8'h50;   // left
         9'h174:  k = 8'h4F;   // right
         default: k = 8'h00;
      endcase
      return k;
   endfunction

   // Synchronizer stages (reset to the idle-high bus level)
   logic          ps2_clk_p0, ps2_clk_p1;
   logic          ps2_data_p0, ps2_data_p1;
   // Glitch filter
   logic [FW-1:0] flt_cnt;
   logic          filt_clk, filt_clk_q;
   logic          fall;
   // Bit FSM
   bit_state_t    bstate;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          par_bit;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_abort;
   // Prefix FSM
   pfx_state_t    pstate;
   logic [7:0]    mapped;

   // ---- stage: pin synchronizer and clock filter ----
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ps2_clk_p0  <= 1'b1;
         ps2_clk_p1  <= 1'b1;
         ps2_data_p0 <= 1'b1;
         ps2_data_p1 <= 1'b1;
         flt_cnt     <= '0;
         filt_clk    <= 1'b1;
         filt_clk_q  <= 1'b1;
      end else begin
         ps2_clk_p0  <= ps2_clk;
         ps2_clk_p1  <= ps2_clk_p0;
         ps2_data_p0 <= ps2_data;
         ps2_data_p1 <= ps2_data_p0;
         filt_clk_q  <= filt_clk;
         // The level flips on the FILTER_LEN-th consecutive disagreeing sample;
         // any agreeing sample restarts the count.
         if (ps2_clk_p1 != filt_clk) begin
            if (flt_cnt == FW'(FILTER_LEN - 1)) begin
               filt_clk <= ~filt_clk;
               flt_cnt  <= '0;
            end else begin
               flt_cnt <= flt_cnt + 1'b1;
            end
         end else begin
            flt_cnt <= '0;
         end
      end
   end

   assign fall = filt_clk_q & ~filt_clk;

   // ---- stage: bit FSM, byte checks and timeout ----
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bstate     <= B_IDLE;
         bit_cnt    <= '0;
         shift      <= '0;
         par_bit    <= 1'b0;
         tmo_cnt    <= '0;
         tmo_abort  <= 1'b0;
         rx_byte    <= '0;
         rx_strobe  <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_strobe  <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         tmo_abort  <= 1'b0;
         // An edge always takes priority over an expiring timeout.
         if (fall) begin
            tmo_cnt <= '0;
            case (bstate)
               B_IDLE: begin
                  if (!ps2_data_p1) begin
                     bstate  <= B_DATA;
                     bit_cnt <= '0;
                  end
               end
               B_DATA: begin
                  shift   <= {ps2_data_p1, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) bstate <= B_PARITY;
               end
               B_PARITY: begin
                  par_bit <= ps2_data_p1;
                  bstate  <= B_STOP;
               end
               default: begin
                  if (^{shift, par_bit} != 1'b1) begin
                     parity_err <= 1'b1;
                  end else if (!ps2_data_p1) begin
                     frame_err <= 1'b1;
                  end else begin
                     rx_byte   <= shift;
                     rx_strobe <= 1'b1;
                  end
                  bstate <= B_IDLE;
               end
            endcase
         end else if (bstate != B_IDLE) begin
            if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               bstate    <= B_IDLE;
               tmo_cnt   <= '0;
               tmo_abort <= 1'b1;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end else begin
            tmo_cnt <= '0;
         end
      end
   end

   assign mapped = map_code(rx_byte, (pstate == P_EXT) || (pstate == P_EXTBRK));

   // ---- stage: prefix decode and held keycode ----
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pstate    <= P_NORM;
         keycode   <= '0;
         key_valid <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (parity_err || frame_err || tmo_abort) begin
            pstate <= P_NORM;
         end else if (rx_strobe) begin
            case (pstate)
               P_NORM: begin
                  if (rx_byte == 8'hE0) begin
                     pstate <= P_EXT;
                  end else if (rx_byte == 8'hF0) begin
                     pstate <= P_BRK;
                  end else if (mapped != 8'h00) begin
                     keycode   <= mapped;
                     key_valid <= 1'b1;
                  end
               end
               P_EXT: begin
                  if (rx_byte == 8'hF0) begin
                     pstate <= P_EXTBRK;
                  end else begin
                     if (mapped != 8'h00) begin
                        keycode   <= mapped;
                        key_valid <= 1'b1;
                     end
                     pstate <= P_NORM;
                  end
               end
               default: begin
                  // Release clears only if it is the key currently held.
                  if (mapped != 8'h00 && mapped == keycode) keycode <= 8'h00;
                  pstate <= P_NORM;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
module tb_ps2_keycode_rx;

   localparam int FLT  = 8;
   localparam int TMO  = 4000;
   localparam int HALF = 25;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] keycode;
   logic       key_valid;
   logic [7:0] rx_byte;
   logic       rx_strobe;
   logic       parity_err;
   logic       frame_err;

   ps2_keycode_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
      .Clk(Clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keycode(keycode), .key_valid(key_valid), .rx_byte(rx_byte),
      .rx_strobe(rx_strobe), .parity_err(parity_err), .frame_err(frame_err)
   );

   always #10 Clk = ~Clk;

   int n_chk = 0;
   int n_err = 0;

   // Observed pulse counts, sampled on the falling edge (a stretched pulse counts twice).
   int cnt_kv = 0, cnt_rx = 0, cnt_pe = 0, cnt_fe = 0;
   always @(negedge Clk) begin
      if (key_valid)  cnt_kv++;
      if (rx_strobe)  cnt_rx++;
      if (parity_err) cnt_pe++;
      if (frame_err)  cnt_fe++;
   end

   // Reference model state
   logic [7:0] m_kc = 8'h00;
   logic [7:0] m_rx = 8'h00;
   bit         m_ext = 1'b0;
   bit         m_brk = 1'b0;
   int e_kv = 0, e_rx = 0, e_pe = 0, e_fe = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_map(input bit ext, input logic [7:0] b);
      logic [7:0] plain [logic [7:0]];
      logic [7:0] extd  [logic [7:0]];
      plain = '{8'h1D:8'h1A, 8'h1B:8'h16, 8'h1C:8'h04, 8'h23:8'h07, 8'h29:8'h2C, 8'h5A:8'h28};
      extd  = '{8'h75:8'h52, 8'h72:8'h51, 8'h6B:8'h50, 8'h74:8'h4F};
      if (ext)  return extd.exists(b)  ? extd[b]  : 8'h00;
      else      return plain.exists(b) ? plain[b] : 8'h00;
   endfunction

   task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
      logic [7:0] k;
      if (!par_ok) begin
         e_pe++; m_ext = 0; m_brk = 0;
      end else if (!stop_ok) begin
         e_fe++; m_ext = 0; m_brk = 0;
      end else begin
         e_rx++; m_rx = b;
         if (!m_ext && !m_brk && b == 8'hE0) m_ext = 1;
         else if (!m_brk && b == 8'hF0) m_brk = 1;
         else begin
            k = ref_map(m_ext, b);
            if (k != 8'h00) begin
               if (m_brk) begin
                  if (m_kc == k) m_kc = 8'h00;
               end else begin
                  m_kc = k; e_kv++;
               end
            end
            m_ext = 0; m_brk = 0;
         end
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic ps2_bit(input bit v);
      ps2_data = v;
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".keycode"}, 32'(keycode), 32'(m_kc));
      chk({tag, ".rx_byte"}, 32'(rx_byte), 32'(m_rx));
      chk({tag, ".n_key_valid"}, cnt_kv, e_kv);
      chk({tag, ".n_rx_strobe"}, cnt_rx, e_rx);
      chk({tag, ".n_parity_err"}, cnt_pe, e_pe);
      chk({tag, ".n_frame_err"}, cnt_fe, e_fe);
   endtask

   task automatic send_frame(input string tag, input logic [7:0] b,
                             input bit bad_par, input bit bad_stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad_par);
      ps2_bit(~bad_stop);
      ps2_data = 1'b1;
      wait_clk(3 * HALF);
      model_frame(b, !bad_par, !bad_stop);
      check_state(tag);
   endtask

   task automatic send_partial(input logic [7:0] b, input int nd);
      ps2_bit(1'b0);
      for (int i = 0; i < nd; i++) ps2_bit(b[i]);
      ps2_data = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".keycode"}, 32'(keycode), 0);
      chk({tag, ".key_valid"}, 32'(key_valid), 0);
      chk({tag, ".rx_byte"}, 32'(rx_byte), 0);
      chk({tag, ".rx_strobe"}, 32'(rx_strobe), 0);
      chk({tag, ".parity_err"}, 32'(parity_err), 0);
      chk({tag, ".frame_err"}, 32'(frame_err), 0);
   endtask

   initial begin
      logic [7:0] pool [6];
      logic [7:0] b;
      int         sel, err;
      pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h5A};

      Reset = 1'b1;
      wait_clk(3);
      check_all_zero("reset");
      Reset = 1'b0;
      wait_clk(HALF);

      // Plain make/break
      send_frame("t1.make_1D", 8'h1D, 0, 0);
      send_frame("t1.brk_F0", 8'hF0, 0, 0);
      send_frame("t1.brk_1D", 8'h1D, 0, 0);

      // Extended make/break, and plain 75 which is unmapped
      send_frame("t2.E0", 8'hE0, 0, 0);
      send_frame("t2.up", 8'h75, 0, 0);
      send_frame("t2.E0b", 8'hE0, 0, 0);
      send_frame("t2.F0", 8'hF0, 0, 0);
      send_frame("t2.up_rel", 8'h75, 0, 0);
      send_frame("t2.plain75", 8'h75, 0, 0);

      // Framing errors
      send_frame("t3.bad_parity", 8'h1D, 1, 0);
      send_frame("t3.bad_stop", 8'h1C, 0, 1);

      // Release of a key that is not held leaves keycode alone
      send_frame("t4.W", 8'h1D, 0, 0);
      send_frame("t4.D", 8'h23, 0, 0);
      send_frame("t4.F0", 8'hF0, 0, 0);
      send_frame("t4.rel_W", 8'h1D, 0, 0);
      send_frame("t4.F0b", 8'hF0, 0, 0);
      send_frame("t4.rel_D", 8'h23, 0, 0);
      for (int i = 0; i < 3; i++) send_frame("t4.typematic_D", 8'h23, 0, 0);

      // Timeout mid-frame, then a complete frame
      send_partial(8'h1C, 4);
      wait_clk(TMO + 1500);
      m_ext = 0; m_brk = 0;
      check_state("t5.after_timeout");
      send_frame("t5.A", 8'h1C, 0, 0);

      // Timeout must also drop a pending E0 prefix
      send_frame("t5.E0", 8'hE0, 0, 0);
      send_partial(8'h75, 3);
      wait_clk(TMO + 1500);
      m_ext = 0; m_brk = 0;
      send_frame("t5.plain75_after_abort", 8'h75, 0, 0);

      // Short glitch on ps2_clk while data is low must not start a frame
      ps2_data = 1'b0;
      wait_clk(5);
      ps2_clk = 1'b0;
      wait_clk(FLT - 3);
      ps2_clk = 1'b1;
      wait_clk(5);
      ps2_data = 1'b1;
      wait_clk(2 * HALF);
      check_state("t5.glitch");
      send_frame("t5.S_after_glitch", 8'h1B, 0, 0);

      // Reset in the middle of a frame while a key is held
      send_frame("t6.D", 8'h23, 0, 0);
      send_partial(8'h1D, 5);
      Reset = 1'b1;
      wait_clk(2);
      check_all_zero("t6.reset");
      Reset = 1'b0;
      m_kc = 8'h00; m_rx = 8'h00; m_ext = 0; m_brk = 0;
      wait_clk(HALF);
      send_frame("t6.S", 8'h1B, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6)       b = pool[sel];
         else if (sel == 6) b = 8'hE0;
         else if (sel == 7) b = 8'hF0;
         else if (sel == 8) b = 8'(32'h70 + $urandom_range(0, 5));
         else               b = 8'($urandom_range(0, 255));
         err = $urandom_range(0, 19);
         send_frame("rnd", b, err == 0, err == 1);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
